// File: rtl/shift_pipe_if.sv
// Issue-side and writeback-side valid/ready bundle for the shift/rotate execute unit.
// master = issue/writeback side, slave = the unit itself.
interface shift_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_tag;
    logic        out_zero;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_cnt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage 16-bit shift/rotate unit: every op is a left rotate by an effective count plus a fill mask.
// Latency 2 edges, one op per cycle; in_ready falls only when both stages are full and out_ready is low.
module shift_pipe (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    shift_pipe_if.slave  bus
);
    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    logic        s1_v_q, s1_v_d;
    logic [2:0]  op_q;
    logic [15:0] data_q;
    logic [3:0]  cnt_q;
    logic [2:0]  tag_q;

    logic        s2_v_q, s2_v_d;
    logic [15:0] res_q, res_d;
    logic [2:0]  otag_q;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic        s1_adv, s2_adv;
    logic [3:0]  eff;
    logic [15:0] r1, r2, r4, r8;
    logic [15:0] lmask, rmask;

    assign s2_adv = !s2_v_q || bus.out_ready;
    assign s1_adv = !s1_v_q || s2_adv;

    // Right shifts become left rotates by the 4-bit two's complement of the count.
    always_comb begin
        eff = (op_q == OP_ROR || op_q == OP_SRL || op_q == OP_SRA) ? (4'd0 - cnt_q) : cnt_q;
        r1  = eff[0] ? {data_q[14:0], data_q[15]}  : data_q;
        r2  = eff[1] ? {r1[13:0], r1[15:14]}        : r1;
        r4  = eff[2] ? {r2[11:0], r2[15:12]}        : r2;
        r8  = eff[3] ? {r4[7:0],  r4[15:8]}         : r4;
        lmask = 16'hFFFF << cnt_q;
        rmask = 16'hFFFF >> cnt_q;
        err_d = 1'b0;
        case (op_q)
            OP_ROL, OP_ROR: res_d = r8;
            OP_SLL:         res_d = r8 & lmask;
            OP_SRL:         res_d = r8 & rmask;
            OP_SRA:         res_d = (r8 & rmask) | (data_q[15] ? ~rmask : 16'h0000);
            default: begin
                res_d = data_q;
                err_d = 1'b1;
            end
        endcase
        zero_d = (res_d == 16'h0000);
    end

    // Flush kills both valid bits and wins over any concurrent input transfer.
    always_comb begin
        s1_v_d = s1_adv ? bus.in_valid : s1_v_q;
        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            op_q   <= 3'd0;
            data_q <= 16'h0000;
            cnt_q  <= 4'd0;
            tag_q  <= 3'd0;
            s2_v_q <= 1'b0;
            res_q  <= 16'h0000;
            otag_q <= 3'd0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (s1_adv) begin
                op_q   <= bus.in_op;
                data_q <= bus.in_data;
                cnt_q  <= bus.in_cnt;
                tag_q  <= bus.in_tag;
            end
            if (s2_adv && s1_v_q) begin
                res_q  <= res_d;
                otag_q <= tag_q;
                zero_q <= zero_d;
                err_q  <= err_d;
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.out_data  = res_q;
    assign bus.out_tag   = otag_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;
endmodule
